control_pipe: RTL and testbench
===============================

# control_pipe

Pipelined main control unit for the MIPS datapath. Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards, bubbles the pipeline on them, and applies branch/jump flushes. Sits beside the register file in ID; its staged outputs drive the ALU, data memory and write-back muxes directly.

## Interface
- `OPCODE_BITS`, 6, opcode field width
- `REG_ADDR_BITS`, 5, register specifier width
- `ALUOP_BITS`, 3, ALU operation code width
---
- `i_clk` input 1: rising-edge clock
- `i_rst_n` input 1: asynchronous, active-low reset
- `i_opcode` input OPCODE_BITS: opcode of the instruction in ID
- `i_id_rs` input REG_ADDR_BITS: rs of the instruction in ID
- `i_id_rt` input REG_ADDR_BITS: rt of the instruction in ID
- `i_flush` input 1: branch taken, resolved in MEM
- `o_pc_write` output 1: PC load enable
- `o_ifid_write` output 1: IF/ID load enable
- `o_ifid_flush` output 1: clear IF/ID
- `o_id_jump` output 1: J opcode in ID (combinational)
- `o_illegal` output 1: undecodable opcode in ID (combinational)
- `o_ex_RegDst`, `o_ex_ALUSrc` output 1 each: EX-stage controls
- `o_ex_ALUOp` output ALUOP_BITS: EX-stage ALU operation
- `o_mem_Branch`, `o_mem_BranchNe`, `o_mem_MemRead`, `o_mem_MemWrite` output 1 each: MEM-stage controls
- `o_wb_RegWrite`, `o_wb_MemtoReg` output 1 each: WB-stage controls

## Operation
- **Decode.** Combinational decode of `i_opcode`:
  - R-type `000000`: RegDst=1, RegWrite=1, ALUOp=`010` (funct field)
  - LW `100011`: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=`000` (add)
  - SW `101011`: ALUSrc=1, MemWrite=1, ALUOp=`000`
  - BEQ `000100`: Branch=1, ALUOp=`001` (sub)
  - BNE `000101`: BranchNe=1, ALUOp=`001`
  - J `000010`: bundle all zero, o_id_jump=1
  - Any other opcode: bundle all zero, o_illegal=1
- **Staging.**
  - ID/EX holds the full bundle plus `ex_rt`.
  - EX/MEM holds the MEM and WB fields.
  - MEM/WB holds the WB fields.
- **Load-use hazard (`stall`).** `stall` = ex_MemRead && ex_rt != 0 && (ex_rt == i_id_rs || ex_rt == i_id_rt).
  - On stall: o_pc_write=0, o_ifid_write=0, and ID/EX loads an all-zero bundle (bubble).
  - EX/MEM and MEM/WB advance normally during a stall.
- **Flush.** When i_flush=1:
  - ID/EX and EX/MEM load zero bundles on the next edge.
  - o_ifid_flush=1 in the same cycle.
  - MEM/WB advances normally, so the branch itself retires.
- **Jump.** o_id_jump=1 also asserts o_ifid_flush. The J bundle entering ID/EX is already zero.
- **Priority.** Flush overrides stall. If both are true in one cycle: o_pc_write=1, o_ifid_write=1, and the flush zeroing applies.
- **Reset.** Reset clears every stage register to zero. While reset is held and out of it, all o_ex/o_mem/o_wb outputs are 0, o_pc_write=1, o_ifid_write=1, o_ifid_flush=0. Asserting reset mid-pipeline discards all in-flight controls immediately (asynchronous).

## Timing
- Latency of the control bundle for an instruction in ID:
  - o_ex_* valid 1 cycle later
  - o_mem_* valid 2 cycles later
  - o_wb_* valid 3 cycles later
- o_pc_write, o_ifid_write, o_ifid_flush, o_id_jump and o_illegal are combinational in the same cycle. They derive only from registered state plus current inputs, with no loop through outputs.
- A stall lasts exactly one cycle: the bubble clears ex_MemRead on the next edge.
- Back-to-back loads with a dependency produce one bubble per dependent pair.

## Configuration
- Macro: `CONTROL_IMM_OPS_EN`.
- **Defined.** Immediate ALU opcodes decode with ALUSrc=1, RegWrite=1:
  - ADDI `001000` → ALUOp `000`
  - ANDI `001100` → ALUOp `011`
  - ORI `001101` → ALUOp `100`
  - SLTI `001010` → ALUOp `101`
  - LUI `001111` → ALUOp `110`
- **Undefined.** These opcodes take the illegal path: zero bundle, o_illegal=1.

## Test plan
- Reset mid-stream: hold i_rst_n=0 with R-type in ID for 2 cycles → all staged outputs 0, o_pc_write=1. Release → o_ex_RegDst=1 one cycle after the R-type is presented.
- Pipeline latency: LW then SW then BEQ, no hazards → o_ex_ALUSrc=1,1,0 on consecutive cycles; o_mem_MemRead=1 at cycle 2, o_mem_MemWrite=1 at cycle 3; o_wb_MemtoReg=1 at cycle 3.
- Load-use: LW rt=5, then R-type with rs=5 → o_pc_write=0 and o_ifid_write=0 for exactly one cycle. The next o_ex bundle is all zero, followed by the R-type bundle.
- Register-zero exemption: LW rt=0, then R-type with rs=0 → no stall, o_pc_write stays 1.
- Flush overrides stall: load-use condition with i_flush=1 in the same cycle → o_pc_write=1, o_ifid_flush=1, and ID/EX and EX/MEM are zero next cycle.
- Immediate opcode: ORI `001101` → o_ex_ALUOp=`100` with the macro defined; o_illegal=1 and a zero bundle without it.

Source files
------------

// File: rtl/control_pipe_if.sv
// rtl/control_pipe_if.sv - control_pipe ID-stage inputs and staged control outputs
interface control_pipe_if #(
    parameter int OPCODE_BITS   = 6,
    parameter int REG_ADDR_BITS = 5,
    parameter int ALUOP_BITS    = 3
);
    logic [OPCODE_BITS-1:0]   i_opcode;
    logic [REG_ADDR_BITS-1:0] i_id_rs;
    logic [REG_ADDR_BITS-1:0] i_id_rt;
    logic                     i_flush;
    logic                     o_pc_write;
    logic                     o_ifid_write;
    logic                     o_ifid_flush;
    logic                     o_id_jump;
    logic                     o_illegal;
    logic                     o_ex_RegDst;
    logic                     o_ex_ALUSrc;
    logic [ALUOP_BITS-1:0]    o_ex_ALUOp;
    logic                     o_mem_Branch;
    logic                     o_mem_BranchNe;
    logic                     o_mem_MemRead;
    logic                     o_mem_MemWrite;
    logic                     o_wb_RegWrite;
    logic                     o_wb_MemtoReg;

    modport master (
        output i_opcode, i_id_rs, i_id_rt, i_flush,
        input  o_pc_write, o_ifid_write, o_ifid_flush, o_id_jump, o_illegal,
        input  o_ex_RegDst, o_ex_ALUSrc, o_ex_ALUOp,
        input  o_mem_Branch, o_mem_BranchNe, o_mem_MemRead, o_mem_MemWrite,
        input  o_wb_RegWrite, o_wb_MemtoReg
    );

    modport slave (
        input  i_opcode, i_id_rs, i_id_rt, i_flush,
        output o_pc_write, o_ifid_write, o_ifid_flush, o_id_jump, o_illegal,
        output o_ex_RegDst, o_ex_ALUSrc, o_ex_ALUOp,
        output o_mem_Branch, o_mem_BranchNe, o_mem_MemRead, o_mem_MemWrite,
        output o_wb_RegWrite, o_wb_MemtoReg
    );
endinterface

// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - pipelined MIPS main control with load-use stall and flush
// Define CONTROL_IMM_OPS_EN to decode ADDI/ANDI/ORI/SLTI/LUI.
module control_pipe #(
    parameter int OPCODE_BITS   = 6,
    parameter int REG_ADDR_BITS = 5,
    parameter int ALUOP_BITS    = 3
) (
    input logic           i_clk,
    input logic           i_rst_n,
    control_pipe_if.slave bus
);
    typedef struct packed {
        logic                  regDst;
        logic                  aluSrc;
        logic [ALUOP_BITS-1:0] aluOp;
        logic                  branch;
        logic                  branchNe;
        logic                  memRead;
        logic                  memWrite;
        logic                  regWrite;
        logic                  memtoReg;
    } ctrl_t;

    typedef struct packed {
        logic branch;
        logic branchNe;
        logic memRead;
        logic memWrite;
        logic regWrite;
        logic memtoReg;
    } memCtrl_t;

    typedef struct packed {
        logic regWrite;
        logic memtoReg;
    } wbCtrl_t;

    localparam logic [OPCODE_BITS-1:0] OP_RTYPE = OPCODE_BITS'(6'b000000);
    localparam logic [OPCODE_BITS-1:0] OP_LW    = OPCODE_BITS'(6'b100011);
    localparam logic [OPCODE_BITS-1:0] OP_SW    = OPCODE_BITS'(6'b101011);
    localparam logic [OPCODE_BITS-1:0] OP_BEQ   = OPCODE_BITS'(6'b000100);
    localparam logic [OPCODE_BITS-1:0] OP_BNE   = OPCODE_BITS'(6'b000101);
    localparam logic [OPCODE_BITS-1:0] OP_J     = OPCODE_BITS'(6'b000010);
`ifdef CONTROL_IMM_OPS_EN
    localparam logic [OPCODE_BITS-1:0] OP_ADDI  = OPCODE_BITS'(6'b001000);
    localparam logic [OPCODE_BITS-1:0] OP_ANDI  = OPCODE_BITS'(6'b001100);
    localparam logic [OPCODE_BITS-1:0] OP_ORI   = OPCODE_BITS'(6'b001101);
    localparam logic [OPCODE_BITS-1:0] OP_SLTI  = OPCODE_BITS'(6'b001010);
    localparam logic [OPCODE_BITS-1:0] OP_LUI   = OPCODE_BITS'(6'b001111);
`endif

    ctrl_t                    idCtrl;
    logic                     idJump;
    logic                     idIllegal;
    ctrl_t                    exCtrl;
    logic [REG_ADDR_BITS-1:0] exRt;
    memCtrl_t                 memCtrl;
    wbCtrl_t                  wbCtrl;
    logic                     stall;

    always_comb begin
        idCtrl    = '0;
        idJump    = 1'b0;
        idIllegal = 1'b0;
        case (bus.i_opcode)
            OP_RTYPE: begin
                idCtrl.regDst   = 1'b1;
                idCtrl.regWrite = 1'b1;
                idCtrl.aluOp    = ALUOP_BITS'(3'b010);
            end
            OP_LW: begin
                idCtrl.aluSrc   = 1'b1;
                idCtrl.memtoReg = 1'b1;
                idCtrl.regWrite = 1'b1;
                idCtrl.memRead  = 1'b1;
            end
            OP_SW: begin
                idCtrl.aluSrc   = 1'b1;
                idCtrl.memWrite = 1'b1;
            end
            OP_BEQ: begin
                idCtrl.branch = 1'b1;
                idCtrl.aluOp  = ALUOP_BITS'(3'b001);
            end
            OP_BNE: begin
                idCtrl.branchNe = 1'b1;
                idCtrl.aluOp    = ALUOP_BITS'(3'b001);
            end
            OP_J: idJump = 1'b1;
`ifdef CONTROL_IMM_OPS_EN
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: begin
                idCtrl.aluSrc   = 1'b1;
                idCtrl.regWrite = 1'b1;
                case (bus.i_opcode)
                    OP_ANDI: idCtrl.aluOp = ALUOP_BITS'(3'b011);
                    OP_ORI:  idCtrl.aluOp = ALUOP_BITS'(3'b100);
                    OP_SLTI: idCtrl.aluOp = ALUOP_BITS'(3'b101);
                    OP_LUI:  idCtrl.aluOp = ALUOP_BITS'(3'b110);
                    default: idCtrl.aluOp = ALUOP_BITS'(3'b000);
                endcase
            end
`endif
            default: idIllegal = 1'b1;
        endcase
    end

    // Register zero never carries a real dependency, so a load to $0 cannot stall.
    assign stall = exCtrl.memRead && (exRt != '0) &&
                   ((exRt == bus.i_id_rs) || (exRt == bus.i_id_rt));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exCtrl  <= '0;
            exRt    <= '0;
            memCtrl <= '0;
            wbCtrl  <= '0;
        end else begin
            if (bus.i_flush || stall) begin
                exCtrl <= '0;
                exRt   <= '0;
            end else begin
                exCtrl <= idCtrl;
                exRt   <= bus.i_id_rt;
            end
            if (bus.i_flush) begin
                memCtrl <= '0;
            end else begin
                memCtrl <= '{branch:   exCtrl.branch,   branchNe: exCtrl.branchNe,
                             memRead:  exCtrl.memRead,  memWrite: exCtrl.memWrite,
                             regWrite: exCtrl.regWrite, memtoReg: exCtrl.memtoReg};
            end
            // The resolving branch sits in EX/MEM and must still retire.
            wbCtrl <= '{regWrite: memCtrl.regWrite, memtoReg: memCtrl.memtoReg};
        end
    end

    assign bus.o_pc_write     = !stall || bus.i_flush;
    assign bus.o_ifid_write   = !stall || bus.i_flush;
    assign bus.o_ifid_flush   = i_rst_n && (bus.i_flush || idJump);
    assign bus.o_id_jump      = idJump;
    assign bus.o_illegal      = idIllegal;
    assign bus.o_ex_RegDst    = exCtrl.regDst;
    assign bus.o_ex_ALUSrc    = exCtrl.aluSrc;
    assign bus.o_ex_ALUOp     = exCtrl.aluOp;
    assign bus.o_mem_Branch   = memCtrl.branch;
    assign bus.o_mem_BranchNe = memCtrl.branchNe;
    assign bus.o_mem_MemRead  = memCtrl.memRead;
    assign bus.o_mem_MemWrite = memCtrl.memWrite;
    assign bus.o_wb_RegWrite  = wbCtrl.regWrite;
    assign bus.o_wb_MemtoReg  = wbCtrl.memtoReg;
endmodule

// File: tb/tb_control_pipe.sv
// tb/tb_control_pipe.sv - directed self-checking bench for control_pipe
module tb_control_pipe;
    localparam logic [5:0] R   = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;
    localparam logic [5:0] J   = 6'b000010;
    localparam logic [5:0] ORI = 6'b001101;
    localparam logic [5:0] BAD = 6'b111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    control_pipe_if #(.OPCODE_BITS(6), .REG_ADDR_BITS(5), .ALUOP_BITS(3)) bus ();

    control_pipe #(.OPCODE_BITS(6), .REG_ADDR_BITS(5), .ALUOP_BITS(3)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic fl);
        bus.i_opcode = op;
        bus.i_id_rs  = rs;
        bus.i_id_rt  = rt;
        bus.i_flush  = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with an R-type in ID
        drive(R, 5'd1, 5'd2, 1'b0);
        tick();
        tick();
        check("rst_ex_regdst", 32'(bus.o_ex_RegDst), 32'd0);
        check("rst_mem_memread", 32'(bus.o_mem_MemRead), 32'd0);
        check("rst_wb_regwrite", 32'(bus.o_wb_RegWrite), 32'd0);
        check("rst_pc_write", 32'(bus.o_pc_write), 32'd1);
        check("rst_ifid_write", 32'(bus.o_ifid_write), 32'd1);
        check("rst_ifid_flush", 32'(bus.o_ifid_flush), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_ex_regdst", 32'(bus.o_ex_RegDst), 32'd1);
        check("rel_ex_aluop", 32'(bus.o_ex_ALUOp), 32'd2);

        // LW, SW, BEQ latency
        drive(LW, 5'd1, 5'd8, 1'b0);
        tick();
        check("lat_lw_alusrc", 32'(bus.o_ex_ALUSrc), 32'd1);
        check("lat_lw_aluop", 32'(bus.o_ex_ALUOp), 32'd0);
        drive(SW, 5'd2, 5'd9, 1'b0);
        check("lat_sw_nostall", 32'(bus.o_pc_write), 32'd1);
        tick();
        check("lat_sw_alusrc", 32'(bus.o_ex_ALUSrc), 32'd1);
        check("lat_lw_memread", 32'(bus.o_mem_MemRead), 32'd1);
        drive(BEQ, 5'd3, 5'd4, 1'b0);
        tick();
        check("lat_beq_alusrc", 32'(bus.o_ex_ALUSrc), 32'd0);
        check("lat_beq_aluop", 32'(bus.o_ex_ALUOp), 32'd1);
        check("lat_sw_memwrite", 32'(bus.o_mem_MemWrite), 32'd1);
        check("lat_sw_memread", 32'(bus.o_mem_MemRead), 32'd0);
        check("lat_lw_memtoreg", 32'(bus.o_wb_MemtoReg), 32'd1);
        check("lat_lw_regwrite", 32'(bus.o_wb_RegWrite), 32'd1);
        drive(R, 5'd10, 5'd11, 1'b0);
        tick();
        check("lat_beq_branch", 32'(bus.o_mem_Branch), 32'd1);
        check("lat_sw_wb_memtoreg", 32'(bus.o_wb_MemtoReg), 32'd0);

        // Load-use hazard
        drive(LW, 5'd1, 5'd5, 1'b0);
        tick();
        drive(R, 5'd5, 5'd6, 1'b0);
        check("lu_pc_write", 32'(bus.o_pc_write), 32'd0);
        check("lu_ifid_write", 32'(bus.o_ifid_write), 32'd0);
        check("lu_ifid_flush", 32'(bus.o_ifid_flush), 32'd0);
        tick();
        check("lu_bubble_regdst", 32'(bus.o_ex_RegDst), 32'd0);
        check("lu_bubble_alusrc", 32'(bus.o_ex_ALUSrc), 32'd0);
        check("lu_bubble_aluop", 32'(bus.o_ex_ALUOp), 32'd0);
        check("lu_lw_memread", 32'(bus.o_mem_MemRead), 32'd1);
        check("lu_one_cycle", 32'(bus.o_pc_write), 32'd1);
        tick();
        check("lu_r_regdst", 32'(bus.o_ex_RegDst), 32'd1);
        check("lu_r_aluop", 32'(bus.o_ex_ALUOp), 32'd2);
        check("lu_bubble_mem", 32'(bus.o_mem_MemRead), 32'd0);
        check("lu_lw_wb", 32'(bus.o_wb_MemtoReg), 32'd1);

        // Register zero never stalls
        drive(LW, 5'd1, 5'd0, 1'b0);
        tick();
        drive(R, 5'd0, 5'd0, 1'b0);
        check("r0_pc_write", 32'(bus.o_pc_write), 32'd1);
        check("r0_ifid_write", 32'(bus.o_ifid_write), 32'd1);
        tick();
        check("r0_ex_regdst", 32'(bus.o_ex_RegDst), 32'd1);

        // Flush overrides a simultaneous load-use stall
        drive(LW, 5'd1, 5'd7, 1'b0);
        tick();
        drive(R, 5'd7, 5'd3, 1'b1);
        check("fl_pc_write", 32'(bus.o_pc_write), 32'd1);
        check("fl_ifid_write", 32'(bus.o_ifid_write), 32'd1);
        check("fl_ifid_flush", 32'(bus.o_ifid_flush), 32'd1);
        tick();
        drive(R, 5'd0, 5'd0, 1'b0);
        check("fl_ex_regdst", 32'(bus.o_ex_RegDst), 32'd0);
        check("fl_ex_aluop", 32'(bus.o_ex_ALUOp), 32'd0);
        check("fl_mem_memread", 32'(bus.o_mem_MemRead), 32'd0);
        check("fl_wb_retires", 32'(bus.o_wb_RegWrite), 32'd1);

        // Jump
        drive(J, 5'd0, 5'd0, 1'b0);
        check("j_id_jump", 32'(bus.o_id_jump), 32'd1);
        check("j_ifid_flush", 32'(bus.o_ifid_flush), 32'd1);
        check("j_illegal", 32'(bus.o_illegal), 32'd0);
        tick();
        check("j_ex_regdst", 32'(bus.o_ex_RegDst), 32'd0);
        check("j_ex_alusrc", 32'(bus.o_ex_ALUSrc), 32'd0);

        // BNE
        drive(BNE, 5'd1, 5'd2, 1'b0);
        check("bne_ifid_flush", 32'(bus.o_ifid_flush), 32'd0);
        tick();
        check("bne_ex_aluop", 32'(bus.o_ex_ALUOp), 32'd1);
        drive(R, 5'd0, 5'd0, 1'b0);
        tick();
        check("bne_mem_branchne", 32'(bus.o_mem_BranchNe), 32'd1);
        check("bne_mem_branch", 32'(bus.o_mem_Branch), 32'd0);

        // ORI depends on the immediate-op build option
        drive(ORI, 5'd1, 5'd2, 1'b0);
`ifdef CONTROL_IMM_OPS_EN
        check("ori_illegal", 32'(bus.o_illegal), 32'd0);
        tick();
        check("ori_ex_aluop", 32'(bus.o_ex_ALUOp), 32'd4);
        check("ori_ex_alusrc", 32'(bus.o_ex_ALUSrc), 32'd1);
`else
        check("ori_illegal", 32'(bus.o_illegal), 32'd1);
        tick();
        check("ori_ex_aluop", 32'(bus.o_ex_ALUOp), 32'd0);
        check("ori_ex_alusrc", 32'(bus.o_ex_ALUSrc), 32'd0);
`endif
        drive(BAD, 5'd1, 5'd2, 1'b0);
        check("bad_illegal", 32'(bus.o_illegal), 32'd1);
        tick();
        check("bad_ex_alusrc", 32'(bus.o_ex_ALUSrc), 32'd0);
        check("bad_ex_regdst", 32'(bus.o_ex_RegDst), 32'd0);

        // Asynchronous reset discards in-flight controls without a clock edge
        drive(LW, 5'd1, 5'd20, 1'b0);
        tick();
        drive(SW, 5'd1, 5'd21, 1'b0);
        tick();
        check("ar_pre_memread", 32'(bus.o_mem_MemRead), 32'd1);
        check("ar_pre_alusrc", 32'(bus.o_ex_ALUSrc), 32'd1);
        drive(J, 5'd0, 5'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("ar_memread", 32'(bus.o_mem_MemRead), 32'd0);
        check("ar_alusrc", 32'(bus.o_ex_ALUSrc), 32'd0);
        check("ar_wb_regwrite", 32'(bus.o_wb_RegWrite), 32'd0);
        check("ar_pc_write", 32'(bus.o_pc_write), 32'd1);
        check("ar_ifid_flush", 32'(bus.o_ifid_flush), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
